// File: rtl/shift_credit_buffer.sv
// Credit-gated issue into a non-stallable fixed-latency shifter.
// Results return into a show-ahead FIFO with a valid/ready output handshake.
module shift_credit_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             issue,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] inflight,
  output logic             err_overflow,
  output logic             err_spurious
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
  localparam logic [PTR_W-1:0] ZERO_PTR  = {PTR_W{1'b0}};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] inflight_r;
  logic             ovf_r;
  logic             spur_r;
  logic [CNT_W:0]   occ_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;
  logic             dec_s;

  // Credit check and FIFO handshake decode; one extra bit keeps the occupancy sum from wrapping
  always_comb begin
    occ_s     = {1'b0, inflight_r} + {1'b0, count_r};
    in_ready  = (occ_s < DEPTH_OCC);
    issue     = in_valid & in_ready;
    full_s    = (count_r == DEPTH_CNT);
    out_valid = (count_r != ZERO_CNT);
    pop_s     = out_valid & out_ready;
    push_s    = res_valid & (~full_s | pop_s);
    dec_s     = res_valid & (inflight_r != ZERO_CNT);
    out_data  = mem_r[rd_ptr_r];
  end

  // Result storage, deliberately left unreset
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= res_data;
    end
  end

  // Pointers, occupancy, in-flight tracking and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r   <= ZERO_PTR;
      wr_ptr_r   <= ZERO_PTR;
      count_r    <= ZERO_CNT;
      inflight_r <= ZERO_CNT;
      ovf_r      <= 1'b0;
      spur_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
      // A spurious result never decrements, so inflight cannot underflow
      case ({issue, dec_s})
        2'b10:   inflight_r <= inflight_r + ONE_CNT;
        2'b01:   inflight_r <= inflight_r - ONE_CNT;
        default: inflight_r <= inflight_r;
      endcase
      if (res_valid && full_s && !pop_s) begin
        ovf_r <= 1'b1;
      end
      if (res_valid && (inflight_r == ZERO_CNT)) begin
        spur_r <= 1'b1;
      end
    end
  end

  assign count        = count_r;
  assign inflight     = inflight_r;
  assign err_overflow = ovf_r;
  assign err_spurious = spur_r;

endmodule

// File: tb/tb_shift_credit_buffer.sv
// Bench for shift_credit_buffer: a 5-cycle shifter model feeds the DUT and a
// queue-based reference predicts every output each cycle.
module tb_shift_credit_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int LAT   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             issue;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic             err_overflow;
  logic             err_spurious;

  always #5 clk = ~clk;

  shift_credit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .issue(issue), .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .inflight(inflight), .err_overflow(err_overflow),
    .err_spurious(err_spurious)
  );

  int          tests = 0;
  int          failed = 0;
  int          n_issue_dut;
  logic        pv [LAT];
  logic [31:0] pd [LAT];
  logic [31:0] mq [$];
  int          m_inflight;
  bit          m_ovf;
  bit          m_spur;
  logic        inj_v;
  logic [31:0] inj_d;
  logic [31:0] next_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive shifter output, check DUT against the model, advance the model
  task automatic cyc();
    bit rv, e_iss, e_pop, e_push, dec, credit;
    rv        = pv[LAT-1] | inj_v;
    res_valid = rv;
    res_data  = inj_v ? inj_d : pd[LAT-1];
    #2;
    credit = (m_inflight + mq.size()) < DEPTH;
    e_iss  = in_valid && credit;
    e_pop  = (mq.size() != 0) && out_ready;
    chk("in_ready", 32'(in_ready), 32'(credit));
    chk("issue", 32'(issue), 32'(e_iss));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("inflight", 32'(inflight), 32'(m_inflight));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_spurious", 32'(err_spurious), 32'(m_spur));
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    if (issue === 1'b1) n_issue_dut++;
    e_push = rv && ((mq.size() < DEPTH) || e_pop);
    if (rv && (mq.size() == DEPTH) && !e_pop) m_ovf = 1'b1;
    if (rv && (m_inflight == 0)) m_spur = 1'b1;
    dec = rv && (m_inflight != 0);
    if (e_pop) void'(mq.pop_front());
    if (e_push) mq.push_back(res_data);
    m_inflight = m_inflight + int'(e_iss) - int'(dec);
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = e_iss;
    pd[0] = next_data;
    if (e_iss) next_data = next_data + 32'd1;
    @(posedge clk);
    #1;
    inj_v = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inj_v     = 1'b0;
    res_valid = 1'b0;
    res_data  = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_inflight = 0;
    m_ovf      = 1'b0;
    m_spur     = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = 32'd0;
    end
  endtask

  initial begin
    inj_d     = 32'd0;
    next_data = 32'd0;
    do_reset();
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", 32'({err_overflow, err_spurious}), 32'd0);

    // Basic pass-through of a single request
    next_data = 32'hDEADBEEF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (8) cyc();
    chk("basic_count", 32'(count), 32'd0);

    // Credit throttle: four issues then stall
    next_data   = 32'd1;
    n_issue_dut = 0;
    in_valid    = 1'b1;
    out_ready   = 1'b0;
    repeat (4) cyc();
    chk("throttle_issues", 32'(n_issue_dut), 32'd4);
    repeat (8) cyc();
    chk("throttle_issues_total", 32'(n_issue_dut), 32'd4);
    chk("throttle_count", 32'(count), 32'd4);
    chk("throttle_inflight", 32'(inflight), 32'd0);
    chk("throttle_in_ready", 32'(in_ready), 32'd0);
    chk("throttle_flags", 32'({err_overflow, err_spurious}), 32'd0);

    // Drain one, refill one, then stream results 1..8 across pointer wrap
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("refill_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("refill_issues", 32'(n_issue_dut), 32'd5);
    for (int i = 0; i < 20; i++) begin
      in_valid  = (next_data <= 32'd8);
      out_ready = 1'b1;
      cyc();
    end
    chk("refill_issues_total", 32'(n_issue_dut), 32'd8);
    chk("refill_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at count==1
    next_data = 32'hA0A00001;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cyc();
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pushpop_count", 32'(count), 32'd1);
    chk("pushpop_data", out_data, 32'hA0A00002);
    out_ready = 1'b1;
    repeat (3) cyc();

    // Spurious result with nothing in flight
    out_ready = 1'b0;
    inj_v     = 1'b1;
    inj_d     = 32'h55555555;
    cyc();
    chk("spurious_flag", 32'(err_spurious), 32'd1);
    out_ready = 1'b1;
    repeat (2) cyc();

    // Overflow: forced result while full and not popping
    next_data = 32'h00000100;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (12) cyc();
    in_valid = 1'b0;
    inj_v    = 1'b1;
    inj_d    = 32'hBAD0BAD0;
    cyc();
    chk("overflow_flag", 32'(err_overflow), 32'd1);
    chk("overflow_count", 32'(count), 32'd4);
    chk("overflow_head", out_data, 32'h00000100);
    out_ready = 1'b1;
    repeat (6) cyc();

    // Reset in the middle of traffic
    next_data = 32'h00000200;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (6) cyc();
    chk("pre_reset_inflight", 32'(inflight), 32'd3);
    do_reset();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_inflight", 32'(inflight), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_flags", 32'({err_overflow, err_spurious}), 32'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      next_data = $urandom;
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) cyc();
    chk("final_empty", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
